set_count_param: RTL and testbench
==================================

# set_count_param

Parametrised lattice-point set counter, the next generation of the fixed 8x8, 3-circle SET engine. It evaluates which points of a GRID_N x GRID_N integer grid fall inside NCIRC circles and counts the points satisfying a selected set expression. Its handshake matches SET (en/busy/valid/candidate), so existing pattern benches drive it unchanged. It adds these features over SET:
- configurable grid size, circle count and coordinate width;
- LANES points evaluated per cycle;
- three extra modes, including an at-least-K threshold mode.

## Interface
- COORD_W, 4: bit width of each centre coordinate and radius (unsigned).
- GRID_N, 8: grid points are x,y in 1..GRID_N; requires GRID_N <= 2^COORD_W - 1.
- NCIRC, 3: number of circles; legal range 3..8. Circle 0 = A, 1 = B, 2 = C.
- LANES, 1: grid points tested per cycle; must divide GRID_N*GRID_N.
- CNT_W, derived: clog2(GRID_N*GRID_N+1); 7 at defaults.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- en  in  1  start request; sampled only when busy=0.
- central  in  NCIRC*2*COORD_W  per circle i: {x_i,y_i} at bits [(2i+2)*COORD_W-1 : 2i*COORD_W]; x in the upper half of each field.
- radius  in  NCIRC*COORD_W  r_i at bits [(i+1)*COORD_W-1 : i*COORD_W].
- mode  in  3  set expression selector (see Operation).
- thresh  in  4  K for mode 110.
- busy  out  1  engine is occupied; en is ignored.
- valid  out  1  one-cycle pulse: candidate holds the new result.
- candidate  out  CNT_W  count of qualifying points.

## Operation
- States are IDLE, CALC and DONE.
- **Reset (rst=0, any time, including mid-CALC):**
  - state goes to IDLE;
  - busy=0, valid=0, candidate=0;
  - the internal accumulator and point index are cleared.
- **IDLE:**
  - en=1 at a clock edge latches central, radius, mode and thresh, clears the accumulator and index, and moves to CALC.
- **CALC:**
  - Each cycle tests LANES consecutive points in row-major order: x fastest, starting at (1,1).
  - Each qualifying point adds 1 to the accumulator.
  - After the last chunk the state moves to DONE.
- **DONE:**
  - candidate is loaded with the final count and valid=1 for exactly one cycle.
  - The next state is IDLE.
- **Membership:** inside_i = (x-x_i)^2 + (y-y_i)^2 <= r_i^2.
  - Differences are signed, COORD_W+1 bits.
  - Squares are 2*COORD_W+2 bits; the sum is one bit wider.
  - No truncation or saturation at any stage.
  - Centres outside the grid (0 or >GRID_N) are legal and handled by the same arithmetic.
- **Modes** (let n = number of circles containing the point):
  - 000: A.
  - 001: A∪B.
  - 010: A xor B.
  - 011: exactly two of A,B,C.
  - 100: union of all NCIRC circles.
  - 101: intersection of all NCIRC circles.
  - 110: n >= thresh; thresh=0 counts every point; thresh>NCIRC gives 0.
  - 111: n odd.
- Inputs are used only from the latched copies, so changing the ports during CALC has no effect.
- candidate holds its value until the next DONE.

## Timing
- Let P = GRID_N*GRID_N/LANES. Take edge 0 as the edge that samples en=1 in IDLE.
- busy: rises after edge 0 and stays 1 through CALC and DONE; falls after edge P+1.
- valid and candidate: candidate updates and valid rises after edge P. Latency is P cycles (64 at defaults, 16 with LANES=4). valid falls after edge P+1.
- en=1 at edge P+1: not sampled, because busy=1 at that edge. The earliest new start is edge P+2. en held high continuously therefore restarts every P+2 cycles.
- en while busy=1: ignored, with no queueing.
- Reset asserted between edge 0 and edge P: no valid pulse is produced. After reset deasserts, candidate=0 and busy=0.

## Test plan
- **Mode 000, radius 0:** A=(4,4), r=0 -> candidate=1 after 64 cycles. Then A=(4,4), r=1 -> 5.
- **Mode 000, corners and off-grid centre:** A=(1,1), r=1 -> 3. A=(0,0), r=1 -> 0. A=(4,4), r=15 -> 64 (no overflow at full grid).
- **Modes 001, 010, 101:**
  - 001: A=(2,2) r1, B=(7,7) r1 -> 10.
  - 010: A=(4,4) r1, B=(5,4) r1 -> 6.
  - 101 (NCIRC=3): the same A and B with C=(4,4) r1 -> 2.
- **Mode 110 and LANES:** thresh=0 -> 64. thresh=4 with NCIRC=3 -> 0. LANES=4 gives identical results, with valid 16 cycles after start.
- **Handshake:** en pulsed at cycle 5 of CALC -> ignored; exactly one valid pulse; busy low one cycle after valid. Port changes during CALC do not alter candidate.
- **Reset mid-CALC:** rst=0 at cycle 30 -> busy, valid and candidate are 0 immediately. A new run after release returns the correct count.

Source files
------------

// File: rtl/set_count_param_if.sv
// Handshake/bus bundle for the lattice-point set counter.
//   en        : start request (sampled by the engine only while idle)
//   central   : packed circle centres, circle i = {x_i, y_i} in 2*COORD_W bits
//   radius    : packed radii, circle i in COORD_W bits
//   mode      : set expression selector
//   thresh    : K for the at-least-K mode
//   busy      : engine occupied, en ignored
//   valid     : one-cycle result strobe
//   candidate : count of qualifying grid points
// master = requester side, slave = counting engine.
interface set_count_param_if #(
  parameter int COORD_W = 4,
  parameter int GRID_N  = 8,
  parameter int NCIRC   = 3
) ();
  localparam int CNT_W = $clog2(GRID_N * GRID_N + 1);

  logic                        en;
  logic [NCIRC*2*COORD_W-1:0]  central;
  logic [NCIRC*COORD_W-1:0]    radius;
  logic [2:0]                  mode;
  logic [3:0]                  thresh;
  logic                        busy;
  logic                        valid;
  logic [CNT_W-1:0]            candidate;

  modport master (output en, central, radius, mode, thresh,
                  input  busy, valid, candidate);
  modport slave  (input  en, central, radius, mode, thresh,
                  output busy, valid, candidate);
endinterface

// File: rtl/set_count_param.sv
// Parametrised lattice-point set counter.
// Scans the GRID_N x GRID_N grid (x,y in 1..GRID_N, x fastest) LANES points
// per cycle, tests each point against NCIRC circles and counts the points
// satisfying the selected set expression.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : set_count_param_if slave (en/central/radius/mode/thresh in,
//         busy/valid/candidate out)
module set_count_param #(
  parameter int COORD_W = 4,
  parameter int GRID_N  = 8,
  parameter int NCIRC   = 3,
  parameter int LANES   = 1
) (
  input  logic             clk,
  input  logic             rst,
  set_count_param_if.slave bus
);
  localparam int NPTS  = GRID_N * GRID_N;
  localparam int P     = NPTS / LANES;
  localparam int IDX_W = (P > 1) ? $clog2(P) : 1;
  localparam int CNT_W = $clog2(NPTS + 1);
  localparam int LC_W  = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_q, state_d;

  logic [NCIRC*2*COORD_W-1:0] central_q;
  logic [NCIRC*COORD_W-1:0]   radius_q;
  logic [2:0]                 mode_q;
  logic [3:0]                 thresh_q;

  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] cand_q;
  logic [LC_W-1:0]  lane_cnt;
  logic             last_chunk;

  int                 pt;
  logic [COORD_W-1:0] px, py;
  logic [NCIRC-1:0]   mask;

  // Exact squared-distance test: differences carry a sign bit and the sum a
  // carry bit, so off-grid centres and the largest radius never wrap.
  function automatic logic in_circle(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y,
                                     input logic [COORD_W-1:0] cx,
                                     input logic [COORD_W-1:0] cy,
                                     input logic [COORD_W-1:0] r);
    logic signed [COORD_W:0]     dx, dy;
    logic signed [2*COORD_W+1:0] sx, sy;
    logic [2*COORD_W+2:0]        sum;
    logic [2*COORD_W-1:0]        rr;
    dx  = $signed({1'b0, x}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, y}) - $signed({1'b0, cy});
    sx  = dx * dx;
    sy  = dy * dy;
    sum = {1'b0, sx} + {1'b0, sy};
    rr  = r * r;
    return sum <= {3'b000, rr};
  endfunction

  function automatic logic point_sel(input logic [NCIRC-1:0] m,
                                     input logic [2:0]       md,
                                     input logic [3:0]       k);
    logic [3:0] n;
    logic [1:0] abc;
    n = '0;
    for (int i = 0; i < NCIRC; i++) n = n + 4'(m[i]);
    abc = 2'(m[0]) + 2'(m[1]) + 2'(m[2]);
    case (md)
      3'b000:  return m[0];
      3'b001:  return m[0] | m[1];
      3'b010:  return m[0] ^ m[1];
      3'b011:  return abc == 2'd2;
      3'b100:  return |m;
      3'b101:  return &m;
      3'b110:  return n >= k;
      default: return n[0];
    endcase
  endfunction

  assign last_chunk = (idx_q == IDX_W'(P - 1));

  // Evaluate one chunk of LANES consecutive row-major points.
  always_comb begin
    lane_cnt = '0;
    pt       = 0;
    px       = '0;
    py       = '0;
    mask     = '0;
    for (int l = 0; l < LANES; l++) begin
      pt = int'(idx_q) * LANES + l;
      px = COORD_W'(pt % GRID_N + 1);
      py = COORD_W'(pt / GRID_N + 1);
      for (int c = 0; c < NCIRC; c++) begin
        mask[c] = in_circle(px, py,
                            central_q[(2*c+1)*COORD_W +: COORD_W],
                            central_q[2*c*COORD_W +: COORD_W],
                            radius_q[c*COORD_W +: COORD_W]);
      end
      lane_cnt = lane_cnt + LC_W'(point_sel(mask, mode_q, thresh_q));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en) state_d = CALC;
      CALC:    if (last_chunk) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Configuration snapshot: ports are only looked at on the start edge.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.en) begin
      central_q <= bus.central;
      radius_q  <= bus.radius;
      mode_q    <= bus.mode;
      thresh_q  <= bus.thresh;
    end
  end

  // Accumulate per chunk; the final chunk lands directly in candidate so the
  // result is visible in DONE, P cycles after the start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= '0;
      idx_q  <= '0;
      cand_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.en) begin
          acc_q <= '0;
          idx_q <= '0;
        end
        CALC: if (last_chunk) begin
          cand_q <= acc_q + CNT_W'(lane_cnt);
        end else begin
          acc_q <= acc_q + CNT_W'(lane_cnt);
          idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.valid     = (state_q == DONE);
  assign bus.candidate = cand_q;
endmodule

// File: tb/tb_set_count_param.sv
// Directed bench for set_count_param: a LANES=1 and a LANES=4 instance share
// clock, reset and stimulus; expected counts are hand-computed.
module tb_set_count_param;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  set_count_param_if #(.COORD_W(4), .GRID_N(8), .NCIRC(3)) b1 ();
  set_count_param_if #(.COORD_W(4), .GRID_N(8), .NCIRC(3)) b4 ();

  assign b4.en      = b1.en;
  assign b4.central = b1.central;
  assign b4.radius  = b1.radius;
  assign b4.mode    = b1.mode;
  assign b4.thresh  = b1.thresh;

  set_count_param #(.COORD_W(4), .GRID_N(8), .NCIRC(3), .LANES(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1));
  set_count_param #(.COORD_W(4), .GRID_N(8), .NCIRC(3), .LANES(4)) u4 (
    .clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_circ(input int i, input logic [3:0] x, input logic [3:0] y,
                          input logic [3:0] r);
    b1.central[i*8 +: 8] = {x, y};
    b1.radius[i*4 +: 4]  = r;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while ((b1.busy || b4.busy) && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
  endtask

  // Start one run and capture result/latency of both instances (-1 = none).
  task automatic do_run(output logic [6:0] c1, output int l1,
                        output logic [6:0] c4, output int l4);
    c1 = '0; c4 = '0; l1 = -1; l4 = -1;
    wait_idle();
    @(negedge clk);
    b1.en = 1'b1;
    @(posedge clk); #1;
    b1.en = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (l1 < 0 && b1.valid) begin l1 = k; c1 = b1.candidate; end
      if (l4 < 0 && b4.valid) begin l4 = k; c4 = b4.candidate; end
      if (l1 >= 0 && l4 >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    b1.en = 1'b0; b1.central = '0; b1.radius = '0; b1.mode = '0; b1.thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (b1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", b1.busy); end
    vectors++;
    if (b1.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", b1.valid); end
    vectors++;
    if (b1.candidate !== 7'd0) begin miscompares++; $display("FAIL reset_cand got %0d want 0", b1.candidate); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mode_a();
    logic [3:0] tx [5] = '{4'd4, 4'd4, 4'd1, 4'd0, 4'd4};
    logic [3:0] ty [5] = '{4'd4, 4'd4, 4'd1, 4'd0, 4'd4};
    logic [3:0] tr [5] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd15};
    int         te [5] = '{1, 5, 3, 0, 64};
    logic [6:0] c1, c4;
    int l1, l4;
    for (int v = 0; v < 5; v++) begin
      set_circ(0, tx[v], ty[v], tr[v]);
      set_circ(1, 4'd0, 4'd0, 4'd0);
      set_circ(2, 4'd0, 4'd0, 4'd0);
      b1.mode = 3'b000; b1.thresh = 4'd0;
      do_run(c1, l1, c4, l4);
      vectors++;
      if (c1 !== 7'(te[v])) begin miscompares++; $display("FAIL mode_a[%0d] cand got %0d want %0d", v, c1, te[v]); end
      vectors++;
      if (l1 !== 64) begin miscompares++; $display("FAIL mode_a[%0d] latency got %0d want 64", v, l1); end
    end
  endtask

  task automatic test_modes_abc();
    logic [2:0] tm [6] = '{3'b010, 3'b101, 3'b011, 3'b100, 3'b111, 3'b110};
    int         te [6] = '{6, 2, 3, 8, 5, 5};
    logic [6:0] c1, c4;
    int l1, l4;
    set_circ(0, 4'd2, 4'd2, 4'd1);
    set_circ(1, 4'd7, 4'd7, 4'd1);
    set_circ(2, 4'd0, 4'd0, 4'd0);
    b1.mode = 3'b001; b1.thresh = 4'd0;
    do_run(c1, l1, c4, l4);
    vectors++;
    if (c1 !== 7'd10) begin miscompares++; $display("FAIL mode_001 cand got %0d want 10", c1); end
    set_circ(0, 4'd4, 4'd4, 4'd1);
    set_circ(1, 4'd5, 4'd4, 4'd1);
    set_circ(2, 4'd4, 4'd4, 4'd1);
    b1.thresh = 4'd2;
    for (int v = 0; v < 6; v++) begin
      b1.mode = tm[v];
      do_run(c1, l1, c4, l4);
      vectors++;
      if (c1 !== 7'(te[v])) begin miscompares++; $display("FAIL mode_%b cand got %0d want %0d", tm[v], c1, te[v]); end
    end
  endtask

  task automatic test_thresh();
    logic [6:0] c1, c4;
    int l1, l4;
    set_circ(0, 4'd4, 4'd4, 4'd0);
    set_circ(1, 4'd4, 4'd4, 4'd0);
    set_circ(2, 4'd4, 4'd4, 4'd0);
    b1.mode = 3'b110;
    b1.thresh = 4'd0;
    do_run(c1, l1, c4, l4);
    vectors++;
    if (c1 !== 7'd64) begin miscompares++; $display("FAIL thresh0 cand got %0d want 64", c1); end
    b1.thresh = 4'd4;
    do_run(c1, l1, c4, l4);
    vectors++;
    if (c1 !== 7'd0) begin miscompares++; $display("FAIL thresh4 cand got %0d want 0", c1); end
  endtask

  task automatic test_lanes();
    logic [2:0] tm [3] = '{3'b000, 3'b010, 3'b110};
    int         te [3] = '{5, 6, 64};
    logic [6:0] c1, c4;
    int l1, l4;
    set_circ(0, 4'd4, 4'd4, 4'd1);
    set_circ(1, 4'd5, 4'd4, 4'd1);
    set_circ(2, 4'd4, 4'd4, 4'd1);
    b1.thresh = 4'd0;
    for (int v = 0; v < 3; v++) begin
      b1.mode = tm[v];
      do_run(c1, l1, c4, l4);
      vectors++;
      if (c4 !== 7'(te[v])) begin miscompares++; $display("FAIL lanes4[%0d] cand got %0d want %0d", v, c4, te[v]); end
      vectors++;
      if (l4 !== 16) begin miscompares++; $display("FAIL lanes4[%0d] latency got %0d want 16", v, l4); end
    end
  endtask

  task automatic test_handshake();
    int pulses, first, busy_after;
    logic [6:0] cand;
    pulses = 0; first = -1; busy_after = -1; cand = '0;
    set_circ(0, 4'd4, 4'd4, 4'd1);
    set_circ(1, 4'd0, 4'd0, 4'd0);
    set_circ(2, 4'd0, 4'd0, 4'd0);
    b1.mode = 3'b000; b1.thresh = 4'd0;
    wait_idle();
    @(negedge clk);
    b1.en = 1'b1;
    @(posedge clk); #1;
    b1.en = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        b1.en = 1'b1;
        set_circ(0, 4'd1, 4'd1, 4'd15);
        b1.mode = 3'b100;
      end
      if (k == 6) b1.en = 1'b0;
      if (b1.valid) begin
        pulses++;
        if (first < 0) begin first = k; cand = b1.candidate; end
      end
      if (first >= 0 && k == first + 1) busy_after = int'(b1.busy);
    end
    vectors++;
    if (pulses !== 1) begin miscompares++; $display("FAIL hs_pulses got %0d want 1", pulses); end
    vectors++;
    if (first !== 64) begin miscompares++; $display("FAIL hs_latency got %0d want 64", first); end
    vectors++;
    if (cand !== 7'd5) begin miscompares++; $display("FAIL hs_cand got %0d want 5", cand); end
    vectors++;
    if (busy_after !== 0) begin miscompares++; $display("FAIL hs_busy_after got %0d want 0", busy_after); end
  endtask

  task automatic test_back_to_back();
    int v0, v1n;
    logic [6:0] c0, c1n;
    v0 = -1; v1n = -1; c0 = '0; c1n = '0;
    set_circ(0, 4'd4, 4'd4, 4'd0);
    b1.mode = 3'b000;
    wait_idle();
    @(negedge clk);
    b1.en = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (b1.valid) begin
        if (v0 < 0) begin v0 = k; c0 = b1.candidate; end
        else if (v1n < 0) begin v1n = k; c1n = b1.candidate; end
      end
      if (v1n >= 0) break;
    end
    b1.en = 1'b0;
    vectors++;
    if (v0 !== 64) begin miscompares++; $display("FAIL b2b_first got %0d want 64", v0); end
    vectors++;
    if (v1n !== 130) begin miscompares++; $display("FAIL b2b_second got %0d want 130", v1n); end
    vectors++;
    if (c0 !== 7'd1 || c1n !== 7'd1) begin miscompares++; $display("FAIL b2b_cand got %0d,%0d want 1,1", c0, c1n); end
  endtask

  task automatic test_reset_mid();
    logic [6:0] c1, c4;
    int l1, l4;
    int seen;
    seen = 0;
    set_circ(0, 4'd4, 4'd4, 4'd1);
    b1.mode = 3'b000;
    wait_idle();
    @(negedge clk);
    b1.en = 1'b1;
    @(posedge clk); #1;
    b1.en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (b1.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", b1.busy); end
    vectors++;
    if (b1.valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %b want 0", b1.valid); end
    vectors++;
    if (b1.candidate !== 7'd0 || b4.candidate !== 7'd0) begin
      miscompares++;
      $display("FAIL midrst_cand got %0d,%0d want 0,0", b1.candidate, b4.candidate);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      if (b1.valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL midrst_novalid got %0d pulses want 0", seen); end
    do_run(c1, l1, c4, l4);
    vectors++;
    if (c1 !== 7'd5 || l1 !== 64) begin miscompares++; $display("FAIL midrst_rerun got %0d@%0d want 5@64", c1, l1); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mode_a();
    test_modes_abc();
    test_thresh();
    test_lanes();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
